adap_quan_mc: RTL and testbench
===============================

Name: adap_quan_mc

Overview:
- Multi-channel, pipelined successor to the combinational ADAP_QUAN G.726 adaptive quantizer.
- Accepts time-multiplexed (D, Y) samples tagged with a channel number and keeps a per-channel rate register.
- Emits the ADPCM codeword I for each sample through a 3-stage valid/ready pipeline.
- Sits in the encoder between the difference-signal subtractor and the bitstream packer.

Parameters:
- NCH, 4: number of channels sharing the block.
- CHW, 2: channel tag width; CHW >= clog2(NCH), minimum 1.
- RATE_RST, 2'b01: reset rate for every channel. Encoding: 11 = 16 kb/s, 10 = 24 kb/s, 01 = 32 kb/s, 00 = 40 kb/s.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input sample valid.
- IN_READY  out  1  block can accept a sample this cycle.
- IN_CH  in  CHW  channel tag of the input sample.
- D  in  16  difference signal, two's complement.
- Y  in  13  quantizer scale factor, unsigned.
- CFG_WE  in  1  rate register write strobe.
- CFG_CH  in  CHW  channel selected for the rate write.
- CFG_RATE  in  2  rate value to write.
- OUT_VALID  out  1  output codeword valid.
- OUT_READY  in  1  downstream accepts the output.
- OUT_CH  out  CHW  channel tag of the output codeword.
- OUT_RATE  out  2  rate used to produce I.
- I  out  5  ADPCM codeword, LSB-aligned; unused upper bits are 0.

Behaviour:
- Reset: all stage valids = 0. OUT_VALID = 0, OUT_CH = 0, OUT_RATE = RATE_RST, I = 0. All channel rate registers = RATE_RST. IN_READY = 1 once RESET is deasserted.
- Handshake: a transfer occurs when VALID and READY are both high at the CLK edge. IN_READY = ~S1_valid | S1_advance. A stage advances when the next stage is empty or is itself advancing; the S3 output advances on OUT_READY. IN_READY is combinationally dependent on OUT_READY. No bubbles: full throughput of 1 sample/clock while OUT_READY = 1.
- Latency: 3 cycles from input acceptance to OUT_VALID, with no stall.
- S1 (log):
  - DS = D[15].
  - DQM = |D|, 15-bit magnitude; D = 16'h8000 gives DQM = 15'h7FFF.
  - EXP = floor(log2(DQM)) + 1 (0..15); EXP = 0 when DQM = 0.
  - MANT = ((DQM << 7) >> EXP) & 7'h7F.
  - DL = {EXP, MANT}, 12 bits.
  - Rate is looked up from the rate register of IN_CH at acceptance and carried down the pipe with the channel tag.
- S2: DLN = (DL − (Y >> 2)) mod 4096, 12-bit wrap.
- S3 (quantize): compare DLN against the G.726 decision-level thresholds for the carried rate to obtain the magnitude; DLN >= 2048 is treated as negative (lowest interval).
  - 16 kb/s: I = DS ? (3 − mag) : mag... applied per the G.726 2-bit code table.
  - 24 kb/s: I = DS ? (7 − mag) : mag.
  - 32 kb/s: I = DS ? (15 − mag) : mag; result 0 replaced by 4'hF.
  - 40 kb/s: I = DS ? (31 − mag) : mag; result 0 replaced by 5'h1F.
- Output hold: while OUT_VALID = 1 and OUT_READY = 0, OUT_CH, OUT_RATE and I are held stable.
- Config write: CFG_WE updates the rate register at the clock edge. A sample accepted on the same edge for the same channel uses the OLD rate. Samples already in flight keep their captured rate.
- Out-of-range tags: IN_CH >= NCH uses channel 0's rate. CFG_CH >= NCH writes are ignored.
- Reset asserted mid-operation: in-flight samples are discarded, with no partial output.

Optional Feature:
- Macro ADAP_QUAN_OVL_CNT_EN.
- Defined: adds output port OVL_CNT (16 bits) and input OVL_CLR (1 bit). OVL_CNT increments on each output transfer whose magnitude is the top interval of its rate table, saturates at 16'hFFFF, and resets to 0 on RESET or OVL_CLR. OVL_CLR has priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset state: hold RESET for 3 cycles → OUT_VALID = 0, I = 0, OUT_RATE = 2'b01, IN_READY = 1; with ADAP_QUAN_OVL_CNT_EN defined, OVL_CNT = 0.
- Zero-code substitution: channel 0 at 32 kb/s, D = 16'h0000, Y = 13'd544 → 3 cycles later OUT_VALID = 1, OUT_CH = 0, I = 5'h0F.
- Bulk vectors: stream the ulaw and alaw enc/{16,24,32,40} homing d.t/y.t files (19880 samples each) round-robin over 4 channels with matching CFG_RATE → every I equals I.t, and OUT_CH sequence is 0, 1, 2, 3, …
- Back-pressure: hold OUT_READY = 0 for 10 cycles with continuous IN_VALID → exactly 3 samples accepted, IN_READY = 0 afterwards, outputs stable; then release → in-order delivery with no loss or duplication.
- Config collision: CFG_WE with CFG_CH = 1, CFG_RATE = 00 on the same edge as a channel-1 sample under rate 01 → that sample's OUT_RATE = 01, the next channel-1 sample's OUT_RATE = 00.
- Mid-flight reset: assert RESET with 3 samples in the pipe → OUT_VALID drops immediately (asynchronous) and no stale output appears after release.

Source files
------------

// File: rtl/adap_quan_mc.sv
// ============================================================================
// adap_quan_mc : multi-channel 3-stage pipelined G.726 adaptive quantizer
// Optional macro ADAP_QUAN_OVL_CNT_EN adds OVL_CNT / OVL_CLR.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adap_quan_mc #(
  parameter int         NCH      = 4,
  parameter int         CHW      = 2,
  parameter logic [1:0] RATE_RST = 2'b01
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [CHW-1:0] IN_CH,
  input  logic [15:0]    D,
  input  logic [12:0]    Y,
  input  logic           CFG_WE,
  input  logic [CHW-1:0] CFG_CH,
  input  logic [1:0]     CFG_RATE,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [CHW-1:0] OUT_CH,
  output logic [1:0]     OUT_RATE,
  output logic [4:0]     I
`ifdef ADAP_QUAN_OVL_CNT_EN
  ,
  output logic [15:0]    OVL_CNT,
  input  logic           OVL_CLR
`endif
);

  localparam logic [1:0]   c_r16 = 2'b11;
  localparam logic [1:0]   c_r24 = 2'b10;
  localparam logic [1:0]   c_r32 = 2'b01;
  localparam logic [CHW:0] c_nch = (CHW+1)'(NCH);

  // Decision levels in log2 units with 7 fractional bits; negatives wrap in 12-bit DLN
  localparam logic signed [11:0] c_th16 [1]  = '{12'sd261};
  localparam logic signed [11:0] c_th24 [3]  = '{12'sd8, 12'sd218, 12'sd331};
  localparam logic signed [11:0] c_th32 [7]  = '{-12'sd124, 12'sd80, 12'sd178, 12'sd246,
                                                 12'sd300, 12'sd349, 12'sd400};
  localparam logic signed [11:0] c_th40 [15] = '{-12'sd122, -12'sd16, 12'sd68, 12'sd139,
                                                 12'sd198, 12'sd250, 12'sd298, 12'sd339,
                                                 12'sd378, 12'sd413, 12'sd445, 12'sd475,
                                                 12'sd502, 12'sd528, 12'sd553};

  function automatic logic [3:0] f_mag(input logic [11:0] dln, input logic [1:0] rate);
    logic signed [11:0] s;
    logic [3:0]         m;
    s = $signed(dln);
    m = 4'd0;
    case (rate)
      c_r16:   for (int k = 0; k < 1; k++)  if (s >= c_th16[k]) m = 4'(k + 1);
      c_r24:   for (int k = 0; k < 3; k++)  if (s >= c_th24[k]) m = 4'(k + 1);
      c_r32:   for (int k = 0; k < 7; k++)  if (s >= c_th32[k]) m = 4'(k + 1);
      default: for (int k = 0; k < 15; k++) if (s >= c_th40[k]) m = 4'(k + 1);
    endcase
    return m;
  endfunction

  function automatic logic [4:0] f_code(input logic [3:0] mag, input logic ds,
                                        input logic [1:0] rate);
    logic [4:0] c;
    case (rate)
      c_r16:   c = {1'b0, ds ? (4'd3 - mag) : mag};
      c_r24:   c = {1'b0, ds ? (4'd7 - mag) : mag};
      c_r32: begin
        c = {1'b0, ds ? (4'd15 - mag) : mag};
        if (c == 5'd0) c = 5'h0F;
      end
      default: begin
        c = ds ? (5'd31 - {1'b0, mag}) : {1'b0, mag};
        if (c == 5'd0) c = 5'h1F;
      end
    endcase
    return c;
  endfunction

  logic [1:0]     r_rate [NCH];
  logic           r_v1, r_v2, r_v3;
  logic           r_ds1, r_ds2;
  logic [11:0]    r_dl1, r_dln2;
  logic [10:0]    r_yq1;
  logic [1:0]     r_rate1, r_rate2, r_rate3;
  logic [CHW-1:0] r_ch1, r_ch2, r_ch3;
  logic [4:0]     r_i3;

  logic           w_s1_adv, w_s2_adv, w_s3_adv;
  logic [15:0]    w_dneg;
  logic [14:0]    w_dqm;
  logic [3:0]     w_exp;
  logic [6:0]     w_mant;
  logic [CHW-1:0] w_idx;
  logic [1:0]     w_rate_in;
  logic [3:0]     w_mag;
  logic [4:0]     w_code;
  logic           w_unused_bits;

  assign w_s3_adv = ~r_v3 | OUT_READY;
  assign w_s2_adv = ~r_v2 | w_s3_adv;
  assign w_s1_adv = ~r_v1 | w_s2_adv;
  assign IN_READY = w_s1_adv;

  // 16'h8000 has no positive counterpart, so its magnitude saturates
  assign w_dneg = 16'd0 - D;
  assign w_dqm  = D[15] ? ((D == 16'h8000) ? 15'h7FFF : w_dneg[14:0]) : D[14:0];

  always_comb begin
    w_exp = 4'd0;
    for (int k = 0; k < 15; k++) if (w_dqm[k]) w_exp = 4'(k + 1);
  end

  assign w_mant        = 7'({w_dqm, 7'd0} >> w_exp);
  assign w_idx         = ({1'b0, IN_CH} < c_nch) ? IN_CH : '0;
  assign w_rate_in     = r_rate[w_idx];
  assign w_mag         = f_mag(r_dln2, r_rate2);
  assign w_code        = f_code(w_mag, r_ds2, r_rate2);
  assign w_unused_bits = &{1'b0, Y[1:0], w_dneg[15]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NCH; k++) r_rate[k] <= RATE_RST;
    end else if (CFG_WE) begin
      for (int k = 0; k < NCH; k++) if (CFG_CH == CHW'(k)) r_rate[k] <= CFG_RATE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_ds1   <= 1'b0;
      r_ds2   <= 1'b0;
      r_dl1   <= '0;
      r_dln2  <= '0;
      r_yq1   <= '0;
      r_rate1 <= RATE_RST;
      r_rate2 <= RATE_RST;
      r_rate3 <= RATE_RST;
      r_ch1   <= '0;
      r_ch2   <= '0;
      r_ch3   <= '0;
      r_i3    <= '0;
    end else begin
      if (w_s1_adv) begin
        r_v1 <= IN_VALID;
        if (IN_VALID) begin
          r_ds1   <= D[15];
          r_dl1   <= {w_exp, w_mant};
          r_yq1   <= Y[12:2];
          r_rate1 <= w_rate_in;
          r_ch1   <= IN_CH;
        end
      end
      if (w_s2_adv) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_ds2   <= r_ds1;
          r_dln2  <= r_dl1 - {1'b0, r_yq1};
          r_rate2 <= r_rate1;
          r_ch2   <= r_ch1;
        end
      end
      if (w_s3_adv) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_i3    <= w_code;
          r_rate3 <= r_rate2;
          r_ch3   <= r_ch2;
        end
      end
    end
  end

  assign OUT_VALID = r_v3;
  assign OUT_CH    = r_ch3;
  assign OUT_RATE  = r_rate3;
  assign I         = r_i3;

`ifdef ADAP_QUAN_OVL_CNT_EN
  logic        r_top3;
  logic [15:0] r_ovl_cnt;
  logic        w_top;

  always_comb begin
    case (r_rate2)
      c_r16:   w_top = (w_mag == 4'd1);
      c_r24:   w_top = (w_mag == 4'd3);
      c_r32:   w_top = (w_mag == 4'd7);
      default: w_top = (w_mag == 4'd15);
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_top3    <= 1'b0;
      r_ovl_cnt <= '0;
    end else begin
      if (w_s3_adv && r_v2) r_top3 <= w_top;
      if (OVL_CLR)
        r_ovl_cnt <= '0;
      else if (r_v3 && OUT_READY && r_top3 && (r_ovl_cnt != 16'hFFFF))
        r_ovl_cnt <= r_ovl_cnt + 16'd1;
    end
  end

  assign OVL_CNT = r_ovl_cnt;
`else
  // Overload counter not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_adap_quan_mc.sv
// ============================================================================
// tb_adap_quan_mc : randomized scoreboard bench for adap_quan_mc
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adap_quan_mc;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           IN_VALID = 1'b0;
  logic           IN_READY;
  logic [CHW-1:0] IN_CH = '0;
  logic [15:0]    D = '0;
  logic [12:0]    Y = '0;
  logic           CFG_WE = 1'b0;
  logic [CHW-1:0] CFG_CH = '0;
  logic [1:0]     CFG_RATE = '0;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b1;
  logic [CHW-1:0] OUT_CH;
  logic [1:0]     OUT_RATE;
  logic [4:0]     I;
`ifdef ADAP_QUAN_OVL_CNT_EN
  logic [15:0]    OVL_CNT;
  logic           OVL_CLR = 1'b0;
  logic [15:0]    m_ovl = '0;
`endif

  adap_quan_mc #(.NCH(NCH), .CHW(CHW), .RATE_RST(2'b01)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CH(IN_CH), .D(D), .Y(Y),
    .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_RATE(CFG_RATE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CH(OUT_CH),
    .OUT_RATE(OUT_RATE), .I(I)
`ifdef ADAP_QUAN_OVL_CNT_EN
    , .OVL_CNT(OVL_CNT), .OVL_CLR(OVL_CLR)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log-domain value of |D|: integer exponent * 128 + 7-bit mantissa
  function automatic int ref_dl(input logic [15:0] d);
    int a, e, m;
    a = d[15] ? ((d == 16'h8000) ? 32767 : 65536 - int'(d)) : int'(d);
    e = 0;
    while (e < 15 && (1 << e) <= a) e++;
    m = ((a * 128) >> e) & 127;
    return e * 128 + m;
  endfunction

  function automatic logic [4:0] ref_code(input logic [15:0] d, input logic [12:0] y,
                                          input logic [1:0] rate, output logic top);
    int dln, mag, full, r;
    int th[$];
    dln = (ref_dl(d) - int'(y) / 4 + 4096) % 4096;
    if (dln >= 2048) dln -= 4096;
    case (rate)
      2'b11:   begin th = '{261};                                   full = 3;  end
      2'b10:   begin th = '{8, 218, 331};                           full = 7;  end
      2'b01:   begin th = '{-124, 80, 178, 246, 300, 349, 400};     full = 15; end
      default: begin th = '{-122, -16, 68, 139, 198, 250, 298, 339, 378,
                            413, 445, 475, 502, 528, 553};          full = 31; end
    endcase
    mag = 0;
    foreach (th[k]) if (dln >= th[k]) mag++;
    top = (mag == th.size());
    r = d[15] ? full - mag : mag;
    if (r == 0 && (rate == 2'b01 || rate == 2'b00)) r = full;
    return 5'(r);
  endfunction

  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] rate;
    logic [4:0] code;
    logic       top;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] m_rate [NCH];
  logic       hold_pend = 1'b0;
  logic [1:0] h_ch, h_rate;
  logic [4:0] h_i;

  always @(negedge CLK) begin
    exp_t e;
    logic tp;
    if (RESET) begin
      exp_q.delete();
      for (int k = 0; k < NCH; k++) m_rate[k] = 2'b01;
      hold_pend = 1'b0;
`ifdef ADAP_QUAN_OVL_CNT_EN
      m_ovl = '0;
`endif
    end else begin
      if (hold_pend && OUT_VALID) begin
        check_eq("hold_ch", OUT_CH, h_ch);
        check_eq("hold_rate", OUT_RATE, h_rate);
        check_eq("hold_i", I, h_i);
      end
`ifdef ADAP_QUAN_OVL_CNT_EN
      check_eq("ovl_cnt", OVL_CNT, m_ovl);
`endif
      if (OUT_VALID && OUT_READY) begin
        check_eq("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_ch", OUT_CH, e.ch);
          check_eq("out_rate", OUT_RATE, e.rate);
          check_eq("out_i", I, e.code);
`ifdef ADAP_QUAN_OVL_CNT_EN
          if (e.top && m_ovl != 16'hFFFF) m_ovl = m_ovl + 16'd1;
`endif
        end
      end
      if (IN_VALID && IN_READY) begin
        e.ch   = IN_CH;
        e.rate = m_rate[IN_CH];
        e.code = ref_code(D, Y, e.rate, tp);
        e.top  = tp;
        exp_q.push_back(e);
        n_acc++;
      end
      if (CFG_WE) m_rate[CFG_CH] = CFG_RATE;
      hold_pend = OUT_VALID && !OUT_READY;
      h_ch = OUT_CH;
      h_rate = OUT_RATE;
      h_i = I;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] rand_d();
    logic [15:0] v;
    case ($urandom_range(0, 9))
      0:       v = 16'h0000;
      1:       v = 16'h8000;
      2:       v = 16'h7FFF;
      3:       v = 16'hFFFF;
      default: begin
        v = 16'($urandom) & 16'((32'd1 << $urandom_range(1, 15)) - 1);
        if ($urandom_range(0, 1) == 1) v = 16'd0 - v;
      end
    endcase
    return v;
  endfunction

  // Y is steered so DLN lands near the decision levels most of the time
  task automatic set_sample(input logic [CHW-1:0] ch);
    logic [15:0] d;
    int yv;
    d = rand_d();
    yv = (ref_dl(d) - (int'($urandom_range(0, 800)) - 200)) * 4 + int'($urandom_range(0, 3));
    if (yv < 0 || yv > 8191) yv = int'($urandom_range(0, 8191));
    IN_CH = ch;
    D = d;
    Y = 13'(yv);
  endtask

  task automatic rand_cycle(input int p_valid, input int p_ready, input int p_cfg);
    IN_VALID = ($urandom_range(0, 99) < p_valid);
    set_sample(CHW'($urandom_range(0, NCH - 1)));
    OUT_READY = ($urandom_range(0, 99) < p_ready);
    CFG_WE = ($urandom_range(0, 99) < p_cfg);
    CFG_CH = CHW'($urandom_range(0, NCH - 1));
    CFG_RATE = 2'($urandom_range(0, 3));
    tick();
  endtask

  task automatic drain();
    IN_VALID = 1'b0;
    CFG_WE = 1'b0;
    OUT_READY = 1'b1;
    repeat (6) tick();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int a0;
    RESET = 1'b1;
    repeat (3) tick();
    check_eq("rst_out_valid", OUT_VALID, 0);
    check_eq("rst_i", I, 0);
    check_eq("rst_out_rate", OUT_RATE, 2'b01);
    check_eq("rst_out_ch", OUT_CH, 0);
`ifdef ADAP_QUAN_OVL_CNT_EN
    check_eq("rst_ovl_cnt", OVL_CNT, 0);
`endif
    RESET = 1'b0;
    #1;
    check_eq("rst_in_ready", IN_READY, 1);

    // Zero-code substitution and 3-cycle latency
    tick();
    IN_VALID = 1'b1; IN_CH = 0; D = 16'h0000; Y = 13'd544;
    tick();
    IN_VALID = 1'b0;
    check_eq("lat_cycle1", OUT_VALID, 0);
    tick();
    check_eq("lat_cycle2", OUT_VALID, 0);
    tick();
    check_eq("zc_valid", OUT_VALID, 1);
    check_eq("zc_ch", OUT_CH, 0);
    check_eq("zc_i", I, 5'h0F);
    tick();

    // Config write colliding with a same-channel sample
    IN_VALID = 1'b1; set_sample(1);
    CFG_WE = 1'b1; CFG_CH = 1; CFG_RATE = 2'b00;
    tick();
    CFG_WE = 1'b0; set_sample(1);
    tick();
    IN_VALID = 1'b0;
    tick();
    check_eq("col_old_rate", OUT_RATE, 2'b01);
    check_eq("col_old_ch", OUT_CH, 1);
    tick();
    check_eq("col_new_rate", OUT_RATE, 2'b00);
    drain();

    repeat (600) rand_cycle(75, 70, 10);
    drain();

    // Back-pressure from an empty pipe
    a0 = n_acc;
    OUT_READY = 1'b0;
    for (int k = 0; k < 10; k++) begin
      IN_VALID = 1'b1;
      set_sample(CHW'(k % NCH));
      tick();
    end
    check_eq("bp_accepted", n_acc - a0, 3);
    check_eq("bp_in_ready", IN_READY, 0);
    check_eq("bp_out_valid", OUT_VALID, 1);
    drain();
    check_eq("bp_total", n_acc - a0, 3);

    // Reset with three samples in flight
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      IN_VALID = 1'b1;
      set_sample(CHW'(k));
      tick();
    end
    IN_VALID = 1'b0;
    check_eq("mfr_full", OUT_VALID, 1);
    #1 RESET = 1'b1;
    #1 check_eq("mfr_valid_drop", OUT_VALID, 0);
    repeat (2) tick();
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("mfr_no_stale", OUT_VALID, 0);
    end

    repeat (150) rand_cycle(90, 85, 5);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
